switch_alloc_rr: RTL and testbench
==================================

Name: switch_alloc_rr

Overview:
- Parametrised header-allocation controller for the NoC router crossbar; next generation of the single-arbiter switch control.
- Round-robin selects one pending header per allocation cycle and waits a programmable routing latency. It then grants one free candidate output port, programs the crossbar selects and acknowledges the input buffer.
- Adds over the previous generation: generic NPORT, multi-candidate (adaptive) routing masks, bounded retry on blocked outputs, route-error flag, deterministic release/grant ordering.

Parameters:
- NPORT, 5, number of router ports (input index i, output index j).
- PW, $clog2(NPORT), select-field width.
- ROUTE_LAT, 1, cycles between latching the selected input and the candidate mask being valid (1..15).
- MAX_RETRY, 3, allocation attempts on a blocked header before yielding (1..15).
- CNT_W, 16, statistics counter width (optional feature only).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-low.
- i_h  in  NPORT  header-pending request per input buffer.
- i_cand  in  NPORT*NPORT  routing candidate output mask; bits [i*NPORT+:NPORT] belong to input i.
- i_sender  in  NPORT  input i still forwarding its packet; a falling edge ends the connection.
- o_ack_h  out  NPORT  one-cycle header acknowledge to input i.
- o_free  out  NPORT  output port j unallocated.
- o_mux_in  out  NPORT*PW  field i = output port assigned to input i.
- o_mux_out  out  NPORT*PW  field j = input port driving output j.
- o_err  out  1  one-cycle pulse on an all-zero candidate mask.

Behaviour:
- Reset (i_rst=0 at posedge): state IDLE, o_ack_h=0, o_free=all 1, o_mux_in=0, o_mux_out=0, o_err=0, rr_ptr=NPORT-1, sel=0, retry=0, sender_prev=0. Reset mid-allocation abandons it, no ack is issued and all connections are dropped.
- IDLE: if |i_h, go to SEL; otherwise stay.
- SEL: winner = first i with i_h[i]=1, scanning rr_ptr+1, rr_ptr+2 … with wrap modulo NPORT. Latch sel=winner and rr_ptr=winner; load lat_cnt=ROUTE_LAT. If i_h is empty here, return to IDLE.
- ROUTE: decrement lat_cnt; move to ALLOC when lat_cnt reaches 1.
- ALLOC: avail = i_cand[sel] & o_free.
  - Candidate mask zero: pulse o_err, retry=0, go to IDLE.
  - avail nonzero: grant j = lowest set bit, go to ACK.
  - avail zero but candidates nonzero: retry+1. If retry reaches MAX_RETRY, clear retry and go to IDLE (yield; rr_ptr already advanced, so other inputs go first). Otherwise stay in ALLOC.
- ACK: one cycle. o_mux_in[sel]=j, o_mux_out[j]=sel, o_free[j]=0, o_ack_h[sel]=1; retry=0; go to IDLE. o_ack_h returns to 0 on the next cycle.
- Handshake: minimum latency from i_h rising to o_ack_h = ROUTE_LAT+4 cycles (IDLE, SEL, ROUTE…, ALLOC, ACK register). At most one ack per allocation. The input must drop i_h within 2 cycles of the ack.
- Release, evaluated every cycle in parallel with the FSM: for each i with sender_prev[i]=1 and i_sender[i]=0, set o_free[o_mux_in[i]]=1. sender_prev <= i_sender. Mux fields are left unchanged, so stale values are harmless.
- Release and grant in the same cycle on different ports: both take effect. The same port cannot collide, because a granted port is not free. A release is visible to ALLOC one cycle later.
- Multiple simultaneous releases: all are applied in the same cycle.

Optional Feature:
- Macro SWALLOC_STATS_EN. When defined, adds two outputs:
  - o_grant_cnt [CNT_W-1:0]: increments on each ACK.
  - o_stall_cnt [CNT_W-1:0]: increments on each blocked ALLOC cycle.
- Both counters saturate at 2^CNT_W-1 and reset to 0.
- When undefined, neither port nor counter exists, and allocation behaviour is identical.

Test Plan:
- Reset then i_h=00100, i_cand[2]=00010 -> o_ack_h=00100 at cycle 5 (ROUTE_LAT=1); o_mux_in[2]=1, o_mux_out[1]=2, o_free=11101.
- i_h=10011 held, each input's candidate a distinct free port, i_h[k] dropped after ack -> grants in order 0,1,4; then 0 again after it re-requests (round-robin wrap).
- Port 1 busy, input 3 candidates=00010, MAX_RETRY=3 -> 3 ALLOC cycles, no ack, FSM in IDLE; stall count +3 with SWALLOC_STATS_EN.
- i_cand[0]=00000 with i_h[0]=1 -> o_err pulses for 1 cycle, no ack, o_free unchanged.
- Input 2 holding port 1, i_sender[2] 1->0 in the same cycle input 4 is granted port 3 -> next cycle o_free[1]=1 and o_free[3]=0.
- Reset asserted during ROUTE -> no o_ack_h, o_free=11111, mux fields 0.

Source files
------------

// File: rtl/switch_alloc_rr_if.sv
// Allocator-facing bundle: header requests, routing candidates and sender status in; acks, free map and crossbar selects out.
// Latency: none, wiring only. Backpressure: none here; the allocator withholds o_ack_h until a candidate port is free.
interface switch_alloc_rr_if #(
    parameter int NPORT = 5,
    parameter int PW    = $clog2(NPORT)
);
    logic [NPORT-1:0]       i_h;
    logic [NPORT*NPORT-1:0] i_cand;
    logic [NPORT-1:0]       i_sender;
    logic [NPORT-1:0]       o_ack_h;
    logic [NPORT-1:0]       o_free;
    logic [NPORT*PW-1:0]    o_mux_in;
    logic [NPORT*PW-1:0]    o_mux_out;
    logic                   o_err;

    // Router input side: drives headers, candidate masks and sender status.
    modport master (
        output i_h, i_cand, i_sender,
        input  o_ack_h, o_free, o_mux_in, o_mux_out, o_err
    );

    // Allocator side.
    modport slave (
        input  i_h, i_cand, i_sender,
        output o_ack_h, o_free, o_mux_in, o_mux_out, o_err
    );
endinterface

// File: rtl/switch_alloc_rr.sv
// Round-robin header allocator: picks one pending input, waits ROUTE_LAT, grants the lowest free candidate output.
// Latency: ROUTE_LAT+4 cycles from i_h to o_ack_h. Backpressure: blocked headers retry MAX_RETRY times, then yield.
// Optional statistics counters (o_grant_cnt, o_stall_cnt) are built when SWALLOC_STATS_EN is defined.
module switch_alloc_rr #(
    parameter int NPORT     = 5,
    parameter int PW        = $clog2(NPORT),
    parameter int ROUTE_LAT = 1,
    parameter int MAX_RETRY = 3
`ifdef SWALLOC_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    switch_alloc_rr_if.slave  bus
`ifdef SWALLOC_STATS_EN
    ,
    output logic [CNT_W-1:0]  o_grant_cnt,
    output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        ROUTE,
        ALLOC,
        ACK
    } state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    gnt;
    logic [3:0]       lat_cnt;
    logic [3:0]       retry;
    logic [NPORT-1:0] sender_prev;

    logic [NPORT-1:0] cand_sel;
    logic [NPORT-1:0] avail;
    logic [NPORT-1:0] rel_mask;
    logic [NPORT-1:0] free_nxt;
    logic [NPORT-1:0] sel_1h;
    logic [NPORT-1:0] gnt_1h;
    logic [PW-1:0]    winner;
    logic             winner_vld;
    logic [PW-1:0]    low_avail;

    assign cand_sel = bus.i_cand[int'(sel)*NPORT +: NPORT];
    assign avail    = cand_sel & bus.o_free;
    assign sel_1h   = NPORT'(1) << sel;
    assign gnt_1h   = NPORT'(1) << gnt;

    // Round-robin scan starting just after the last winner.
    always_comb begin : rr_scan
        int idx;
        idx        = 0;
        winner     = '0;
        winner_vld = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            if (!winner_vld && bus.i_h[idx]) begin
                winner     = PW'(idx);
                winner_vld = 1'b1;
            end
        end
    end

    always_comb begin
        low_avail = '0;
        for (int j = NPORT - 1; j >= 0; j--) begin
            if (avail[j]) begin
                low_avail = PW'(j);
            end
        end
    end

    // A falling sender frees whatever output its mux field points at.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (sender_prev[i] && !bus.i_sender[i]) begin
                rel_mask[bus.o_mux_in[i*PW +: PW]] = 1'b1;
            end
        end
    end

    assign free_nxt = bus.o_free | rel_mask;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= IDLE;
            rr_ptr        <= PW'(NPORT - 1);
            sel           <= '0;
            gnt           <= '0;
            lat_cnt       <= '0;
            retry         <= '0;
            sender_prev   <= '0;
            bus.o_ack_h   <= '0;
            bus.o_free    <= '1;
            bus.o_mux_in  <= '0;
            bus.o_mux_out <= '0;
            bus.o_err     <= 1'b0;
        end else begin
            sender_prev <= bus.i_sender;
            bus.o_ack_h <= '0;
            bus.o_err   <= 1'b0;
            bus.o_free  <= free_nxt;

            case (state)
                IDLE: begin
                    if (|bus.i_h) begin
                        state <= SEL;
                    end
                end

                SEL: begin
                    if (winner_vld) begin
                        sel     <= winner;
                        rr_ptr  <= winner;
                        lat_cnt <= 4'(ROUTE_LAT);
                        state   <= ROUTE;
                    end else begin
                        state <= IDLE;
                    end
                end

                ROUTE: begin
                    if (lat_cnt <= 4'd1) begin
                        state <= ALLOC;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                ALLOC: begin
                    if (cand_sel == '0) begin
                        bus.o_err <= 1'b1;
                        retry     <= '0;
                        state     <= IDLE;
                    end else if (avail != '0) begin
                        gnt   <= low_avail;
                        state <= ACK;
                    end else if (retry == 4'(MAX_RETRY - 1)) begin
                        // Yield: rr_ptr already points at this input, so others scan first.
                        retry <= '0;
                        state <= IDLE;
                    end else begin
                        retry <= retry + 4'd1;
                    end
                end

                ACK: begin
                    // Release is applied first, then the grant clears its port.
                    bus.o_free                     <= free_nxt & ~gnt_1h;
                    bus.o_mux_in[int'(sel)*PW +: PW]  <= gnt;
                    bus.o_mux_out[int'(gnt)*PW +: PW] <= sel;
                    bus.o_ack_h                    <= sel_1h;
                    retry                          <= '0;
                    state                          <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SWALLOC_STATS_EN
    logic stall;
    assign stall = (state == ALLOC) && (cand_sel != '0) && (avail == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_grant_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (state == ACK && o_grant_cnt != '1) begin
                o_grant_cnt <= o_grant_cnt + 1'b1;
            end
            if (stall && o_stall_cnt != '1) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Directed bench for switch_alloc_rr: vector table of single allocations plus round-robin, retry, release and reset sequences.
module tb_switch_alloc_rr;

    localparam int N  = 5;
    localparam int PW = 3;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    switch_alloc_rr_if #(.NPORT(N), .PW(PW)) bus ();

`ifdef SWALLOC_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    switch_alloc_rr #(
        .NPORT(N),
        .PW(PW),
        .ROUTE_LAT(1),
        .MAX_RETRY(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
`ifdef SWALLOC_STATS_EN
        ,
        .o_grant_cnt(grant_cnt),
        .o_stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   h;
        logic [N*N-1:0] cand;
        logic [N-1:0]   exp_ack;
        int             exp_win;
        int             exp_port;
        logic [N-1:0]   exp_free;
        logic           exp_err;
        int             exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*N-1:0] cm(input int i, input logic [N-1:0] m);
        logic [N*N-1:0] t;
        t = {{(N*N-N){1'b0}}, m};
        return t << (i * N);
    endfunction

    function automatic logic [31:0] mux_in_f(input int i);
        return 32'(bus.o_mux_in[i*PW +: PW]);
    endfunction

    function automatic logic [31:0] mux_out_f(input int j);
        return 32'(bus.o_mux_out[j*PW +: PW]);
    endfunction

    task automatic do_reset;
        rst          = 1'b0;
        bus.i_h      = '0;
        bus.i_cand   = '0;
        bus.i_sender = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Waits for an ack or error pulse; lat counts clock edges from the call.
    task automatic wait_resp(input string name, output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        for (int c = 1; c <= 40 && !done; c++) begin
            tick();
            if (bus.o_ack_h != '0 || bus.o_err) begin
                lat  = c;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: no response within 40 cycles", name);
        end
    endtask

    initial begin
        int lat;
        int order[3];
        int seen;

        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;

        vecs[0] = '{5'b00100, cm(2, 5'b00010), 5'b00100, 2, 1, 5'b11101, 1'b0, 5};
        vecs[1] = '{5'b10011, cm(0, 5'b01000) | cm(1, 5'b00001) | cm(4, 5'b00001),
                    5'b00001, 0, 3, 5'b10111, 1'b0, 5};
        vecs[2] = '{5'b10000, cm(4, 5'b11000), 5'b10000, 4, 3, 5'b10111, 1'b0, 5};
        vecs[3] = '{5'b00001, '0, 5'b00000, 0, 0, 5'b11111, 1'b1, 4};
        vecs[4] = '{5'b01010, cm(1, 5'b10100) | cm(3, 5'b00001), 5'b00010, 1, 2, 5'b11011, 1'b0, 5};
        vecs[5] = '{5'b11111, cm(0, 5'b10000) | cm(1, 5'b10000) | cm(2, 5'b10000) |
                    cm(3, 5'b10000) | cm(4, 5'b10000), 5'b00001, 0, 4, 5'b01111, 1'b0, 5};

        do_reset();
        chk("reset_ack", 32'(bus.o_ack_h), 32'h0);
        chk("reset_free", 32'(bus.o_free), 32'h1f);
        chk("reset_mux_in", 32'(bus.o_mux_in), 32'h0);
        chk("reset_mux_out", 32'(bus.o_mux_out), 32'h0);
        chk("reset_err", 32'(bus.o_err), 32'h0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.i_h    = vecs[v].h;
            bus.i_cand = vecs[v].cand;
            wait_resp($sformatf("vec%0d_wait", v), lat);
            bus.i_h = '0;
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("vec%0d_ack", v), 32'(bus.o_ack_h), 32'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_err", v), 32'(bus.o_err), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_free", v), 32'(bus.o_free), 32'(vecs[v].exp_free));
            if (vecs[v].exp_err) begin
                chk($sformatf("vec%0d_mux_in", v), 32'(bus.o_mux_in), 32'h0);
            end else begin
                chk($sformatf("vec%0d_mux_in", v), mux_in_f(vecs[v].exp_win), 32'(vecs[v].exp_port));
                chk($sformatf("vec%0d_mux_out", v), mux_out_f(vecs[v].exp_port), 32'(vecs[v].exp_win));
            end
            tick();
            chk($sformatf("vec%0d_pulse_ack", v), 32'(bus.o_ack_h), 32'h0);
            chk($sformatf("vec%0d_pulse_err", v), 32'(bus.o_err), 32'h0);
        end

        // Round-robin: inputs 0,1,4 pending, served in scan order, then 0 again after wrap.
        do_reset();
        order[0] = 0; order[1] = 1; order[2] = 4;
        bus.i_cand = cm(0, 5'b00001) | cm(1, 5'b00010) | cm(4, 5'b10000);
        bus.i_h    = 5'b10011;
        for (int k = 0; k < 3; k++) begin
            wait_resp($sformatf("rr%0d_wait", k), lat);
            chk($sformatf("rr%0d_lat", k), 32'(lat), 32'd5);
            chk($sformatf("rr%0d_ack", k), 32'(bus.o_ack_h), 32'(1) << order[k]);
            bus.i_h = bus.i_h & ~bus.o_ack_h;
        end
        chk("rr_free3", 32'(bus.o_free), 32'h0c);
        bus.i_cand = bus.i_cand | cm(0, 5'b00100);
        bus.i_cand[4:0] = 5'b00100;
        bus.i_h = 5'b00001;
        wait_resp("rr_wrap_wait", lat);
        bus.i_h = '0;
        chk("rr_wrap_ack", 32'(bus.o_ack_h), 32'h01);
        chk("rr_wrap_mux_in0", mux_in_f(0), 32'd2);
        chk("rr_wrap_free", 32'(bus.o_free), 32'h08);

        // Blocked retry: input 3 wants busy port 1, yields after 3 ALLOC cycles, input 4 then served.
        do_reset();
        bus.i_cand = cm(2, 5'b00010);
        bus.i_h    = 5'b00100;
        wait_resp("retry_setup", lat);
        bus.i_cand = cm(3, 5'b00010) | cm(4, 5'b00100);
        bus.i_h    = 5'b11000;
        wait_resp("retry_wait", lat);
        chk("retry_lat", 32'(lat), 32'd11);
        chk("retry_ack", 32'(bus.o_ack_h), 32'h10);
        chk("retry_err", 32'(bus.o_err), 32'h0);
        chk("retry_mux_in4", mux_in_f(4), 32'd2);
        chk("retry_free", 32'(bus.o_free), 32'h19);
`ifdef SWALLOC_STATS_EN
        chk("stats_stall", 32'(stall_cnt), 32'd3);
        chk("stats_grant", 32'(grant_cnt), 32'd2);
`endif
        bus.i_h = '0;

        // Release of port 1 coinciding with the grant of port 3.
        do_reset();
        bus.i_sender = 5'b00100;
        bus.i_cand   = cm(2, 5'b00010);
        bus.i_h      = 5'b00100;
        wait_resp("rel_setup", lat);
        bus.i_cand = cm(4, 5'b01000);
        bus.i_h    = 5'b10000;
        for (int c = 0; c < 4; c++) tick();
        chk("rel_free_before", 32'(bus.o_free), 32'h1d);
        bus.i_sender = 5'b00000;
        tick();
        chk("rel_ack", 32'(bus.o_ack_h), 32'h10);
        chk("rel_free_after", 32'(bus.o_free), 32'h17);
        bus.i_h = '0;

        // Two connections released on the same edge.
        do_reset();
        bus.i_sender = 5'b00101;
        bus.i_cand   = cm(0, 5'b10000) | cm(2, 5'b00010);
        bus.i_h      = 5'b00101;
        wait_resp("multi_wait0", lat);
        chk("multi_ack0", 32'(bus.o_ack_h), 32'h01);
        bus.i_h = bus.i_h & ~bus.o_ack_h;
        wait_resp("multi_wait1", lat);
        chk("multi_ack1", 32'(bus.o_ack_h), 32'h04);
        bus.i_h = '0;
        chk("multi_free_held", 32'(bus.o_free), 32'h0d);
        bus.i_sender = '0;
        tick();
        chk("multi_free_rel", 32'(bus.o_free), 32'h1f);
        chk("multi_stale_mux", mux_in_f(0), 32'd4);

        // Reset while in ROUTE drops connections and suppresses the pending ack.
        do_reset();
        bus.i_cand = cm(2, 5'b00010);
        bus.i_h    = 5'b00100;
        wait_resp("rst_setup", lat);
        bus.i_cand = cm(4, 5'b01000);
        bus.i_h    = 5'b10000;
        tick();
        tick();
        rst     = 1'b0;
        bus.i_h = '0;
        tick();
        rst = 1'b1;
        chk("rst_mid_free", 32'(bus.o_free), 32'h1f);
        chk("rst_mid_mux_in", 32'(bus.o_mux_in), 32'h0);
        chk("rst_mid_mux_out", 32'(bus.o_mux_out), 32'h0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.o_ack_h != '0) seen++;
        end
        chk("rst_mid_no_ack", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
